// File: rtl/text_console.sv
// text_console: byte-stream terminal writer for the on-screen text display.
// Accepts ASCII bytes over valid/ready, tracks a cursor, interprets control
// codes, and emits one {x, y, char} write per cycle into the character buffer.
// Optional feature: define TEXT_CONSOLE_CLEAR_EN to clear the whole screen
// automatically after reset deasserts.
module text_console #(
    parameter int unsigned COLS = 32,
    parameter int unsigned ROWS = 28
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [3:0]  reg_char_we,
    output logic [31:0] reg_char_di,
    output logic [4:0]  cursor_x,
    output logic [4:0]  cursor_y,
    output logic        busy
);

    localparam int unsigned CW     = 5;
    localparam logic [CW-1:0] X_LAST = CW'(COLS - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(ROWS - 1);
    localparam logic [7:0]  SPACE  = 8'h20;
    localparam logic [7:0]  QMARK  = 8'h3F;
    localparam logic [3:0]  WE_ALL = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        ESC_X,
        ESC_Y,
        CLRLINE,
        CLRALL
    } state_t;

    state_t        state;
    logic [CW-1:0] clr_x;
    logic [CW-1:0] clr_y;

    logic          accept;
    logic [7:0]    glyph;
    logic [CW-1:0] row_next;
    logic [CW-1:0] esc_col;
    logic [CW-1:0] esc_row;

    // Display word layout: {8'h00, 3'b0, x, 3'b0, y, char}.
    function automatic logic [31:0] pack_word(input logic [4:0] x,
                                              input logic [4:0] y,
                                              input logic [7:0] c);
        return {8'h00, 3'b000, x, 3'b000, y, c};
    endfunction

    // Handshake, glyph substitution, row wrap and escape clamping.
    assign accept   = in_valid & in_ready;
    assign glyph    = in_data[7] ? QMARK : in_data;
    assign row_next = (cursor_y == Y_LAST) ? CW'(0) : cursor_y + CW'(1);
    assign esc_col  = (in_data > {3'b000, X_LAST}) ? X_LAST : in_data[4:0];
    assign esc_row  = (in_data > {3'b000, Y_LAST}) ? Y_LAST : in_data[4:0];

    // Control FSM: byte interpretation, cursor tracking and clear sequencing.
    always_ff @(posedge clk) begin
        if (reset) begin
`ifdef TEXT_CONSOLE_CLEAR_EN
            state       <= CLRALL;
`else
            state       <= IDLE;
`endif
            clr_x       <= '0;
            clr_y       <= '0;
            cursor_x    <= '0;
            cursor_y    <= '0;
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            reg_char_we <= 4'h0;
            reg_char_di <= '0;
        end else begin
            reg_char_we <= 4'h0;
            in_ready    <= 1'b1;
            busy        <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_data >= 8'h20 && in_data != 8'h7F) begin
                            // Printable (high bytes shown as '?'), wrap clears the new row.
                            reg_char_we <= WE_ALL;
                            reg_char_di <= pack_word(cursor_x, cursor_y, glyph);
                            if (cursor_x == X_LAST) begin
                                cursor_x <= '0;
                                cursor_y <= row_next;
                                clr_x    <= '0;
                                clr_y    <= row_next;
                                state    <= CLRLINE;
                                in_ready <= 1'b0;
                                busy     <= 1'b1;
                            end else begin
                                cursor_x <= cursor_x + CW'(1);
                            end
                        end else begin
                            case (in_data)
                                8'h0A: begin
                                    // Line feed: first clear write goes out immediately.
                                    cursor_x    <= '0;
                                    cursor_y    <= row_next;
                                    reg_char_we <= WE_ALL;
                                    reg_char_di <= pack_word(5'd0, row_next, SPACE);
                                    in_ready    <= 1'b0;
                                    busy        <= 1'b1;
                                    if (X_LAST != CW'(0)) begin
                                        clr_x <= CW'(1);
                                        clr_y <= row_next;
                                        state <= CLRLINE;
                                    end
                                end
                                8'h0D: begin
                                    cursor_x <= '0;
                                end
                                8'h08: begin
                                    if (cursor_x != CW'(0)) begin
                                        cursor_x    <= cursor_x - CW'(1);
                                        reg_char_we <= WE_ALL;
                                        reg_char_di <= pack_word(cursor_x - CW'(1), cursor_y, SPACE);
                                    end
                                end
                                8'h0C: begin
                                    // Form feed: home cursor, first clear write at (0,0).
                                    cursor_x    <= '0;
                                    cursor_y    <= '0;
                                    reg_char_we <= WE_ALL;
                                    reg_char_di <= pack_word(5'd0, 5'd0, SPACE);
                                    in_ready    <= 1'b0;
                                    busy        <= 1'b1;
                                    if (X_LAST != CW'(0)) begin
                                        clr_x <= CW'(1);
                                        clr_y <= '0;
                                        state <= CLRALL;
                                    end else if (Y_LAST != CW'(0)) begin
                                        clr_x <= '0;
                                        clr_y <= CW'(1);
                                        state <= CLRALL;
                                    end
                                end
                                8'h1B: begin
                                    state <= ESC_X;
                                end
                                default: begin
                                end
                            endcase
                        end
                    end
                end
                ESC_X: begin
                    if (accept) begin
                        cursor_x <= esc_col;
                        state    <= ESC_Y;
                    end
                end
                ESC_Y: begin
                    if (accept) begin
                        cursor_y <= esc_row;
                        state    <= IDLE;
                    end
                end
                CLRLINE: begin
                    reg_char_we <= WE_ALL;
                    reg_char_di <= pack_word(clr_x, clr_y, SPACE);
                    in_ready    <= 1'b0;
                    busy        <= 1'b1;
                    if (clr_x == X_LAST) begin
                        state <= IDLE;
                    end else begin
                        clr_x <= clr_x + CW'(1);
                    end
                end
                CLRALL: begin
                    reg_char_we <= WE_ALL;
                    reg_char_di <= pack_word(clr_x, clr_y, SPACE);
                    in_ready    <= 1'b0;
                    busy        <= 1'b1;
                    if (clr_x == X_LAST) begin
                        clr_x <= '0;
                        if (clr_y == Y_LAST) begin
                            state <= IDLE;
                        end else begin
                            clr_y <= clr_y + CW'(1);
                        end
                    end else begin
                        clr_x <= clr_x + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_console.sv
// tb_text_console: randomized and directed bench for text_console with a
// screen-level reference model (cursor arithmetic plus expected write list).
`timescale 1ns/1ps
module tb_text_console;

    localparam int unsigned COLS = 32;
    localparam int unsigned ROWS = 28;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic [3:0]  reg_char_we;
    logic [31:0] reg_char_di;
    logic [4:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int          mx, my, mesc;
    logic [31:0] exp_q[$];
    logic [35:0] cap_q[$];

    text_console #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .reg_char_we(reg_char_we),
        .reg_char_di(reg_char_di),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Record every display write seen by the buffer
    always @(posedge clk) begin
        #1;
        if (reg_char_we !== 4'h0) cap_q.push_back({reg_char_we, reg_char_di});
    end

    function automatic logic [31:0] word(input int x, input int y, input int c);
        logic [4:0] xs;
        logic [4:0] ys;
        logic [7:0] cs;
        xs = 5'(x);
        ys = 5'(y);
        cs = 8'(c);
        return {8'h00, 3'b000, xs, 3'b000, ys, cs};
    endfunction

    task automatic model_clear_row(input int y);
        for (int x = 0; x < int'(COLS); x++) exp_q.push_back(word(x, y, 32));
    endtask

    task automatic model_byte(input logic [7:0] b);
        int v;
        v = int'(b);
        if (mesc == 1) begin
            mx = (v > int'(COLS) - 1) ? int'(COLS) - 1 : v;
            mesc = 2;
        end else if (mesc == 2) begin
            my = (v > int'(ROWS) - 1) ? int'(ROWS) - 1 : v;
            mesc = 0;
        end else if (v == 8'h1B) begin
            mesc = 1;
        end else if (v == 8'h0A) begin
            mx = 0;
            my = (my + 1) % int'(ROWS);
            model_clear_row(my);
        end else if (v == 8'h0D) begin
            mx = 0;
        end else if (v == 8'h08) begin
            if (mx > 0) begin
                mx = mx - 1;
                exp_q.push_back(word(mx, my, 32));
            end
        end else if (v == 8'h0C) begin
            mx = 0;
            my = 0;
            for (int y = 0; y < int'(ROWS); y++) model_clear_row(y);
        end else if (v >= 32 && v != 127) begin
            exp_q.push_back(word(mx, my, (v >= 128) ? 63 : v));
            mx = mx + 1;
            if (mx == int'(COLS)) begin
                mx = 0;
                my = (my + 1) % int'(ROWS);
                model_clear_row(my);
            end
        end
    endtask

    // Drive one byte; returns at the negedge after it was accepted
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end else begin
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic put(input logic [7:0] b);
        model_byte(b);
        send_byte(b);
    endtask

    task automatic settle();
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL settle_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        settle();
        mx = 0;
        my = 0;
        mesc = 0;
        exp_q.delete();
        cap_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({reg_char_we, reg_char_di, cursor_x, cursor_y, in_ready, busy} !== 48'h0) begin
            n_err++;
            $display("FAIL reset_outputs: we=%h di=%h cx=%0d cy=%0d rdy=%b busy=%b, required all zero",
                     reg_char_we, reg_char_di, cursor_x, cursor_y, in_ready, busy);
        end
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: rdy=%b busy=%b, required rdy=1 busy=0", in_ready, busy);
        end
        settle();
        mx = 0; my = 0; mesc = 0;
        exp_q.delete();
        cap_q.delete();
    endtask

    task automatic test_printable();
        do_reset();
        put(8'h41);
        n_vec++;
        if (reg_char_we !== 4'hF || reg_char_di !== 32'h0000_0041 || cursor_x !== 5'd1 || cursor_y !== 5'd0) begin
            n_err++;
            $display("FAIL printable_A: we=%h di=%h cx=%0d cy=%0d, required we=f di=00000041 cx=1 cy=0",
                     reg_char_we, reg_char_di, cursor_x, cursor_y);
        end
    endtask

    task automatic test_wrap();
        int bad;
        do_reset();
        put(8'h1B); put(8'd31); put(8'd5);
        put(8'h5A);
        n_vec++;
        if (reg_char_we !== 4'hF || reg_char_di !== 32'h001F_055A || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_char: we=%h di=%h rdy=%b, required we=f di=001f055a rdy=0",
                     reg_char_we, reg_char_di, in_ready);
        end
        bad = -1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (bad < 0 && (reg_char_we !== 4'hF || reg_char_di !== word(i, 6, 32) ||
                            in_ready !== 1'b0 || busy !== 1'b1)) bad = i;
        end
        n_vec++;
        if (bad >= 0) begin
            n_err++;
            $display("FAIL wrap_clear: first bad clear cycle %0d (we=%h di=%h rdy=%b busy=%b), required row 6 spaces with rdy=0",
                     bad, reg_char_we, reg_char_di, in_ready, busy);
        end
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1 || reg_char_we !== 4'h0 || cursor_x !== 5'd0 || cursor_y !== 5'd6) begin
            n_err++;
            $display("FAIL wrap_end: rdy=%b we=%h cx=%0d cy=%0d, required rdy=1 we=0 cx=0 cy=6",
                     in_ready, reg_char_we, cursor_x, cursor_y);
        end
    endtask

    task automatic test_lf_last_row();
        int bad;
        do_reset();
        put(8'h1B); put(8'd0); put(8'd27);
        put(8'h0A);
        n_vec++;
        if (reg_char_we !== 4'hF || reg_char_di !== 32'h0000_0020 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL lf_first: we=%h di=%h rdy=%b, required we=f di=00000020 rdy=0",
                     reg_char_we, reg_char_di, in_ready);
        end
        settle();
        bad = -1;
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
            if (bad < 0 && cap_q[i] !== {4'hF, exp_q[i]}) bad = i;
        n_vec++;
        if (cap_q.size() != 32 || exp_q.size() != 32 || bad >= 0) begin
            n_err++;
            $display("FAIL lf_writes: got %0d writes (model %0d), first bad index %0d, required 32 matching",
                     cap_q.size(), exp_q.size(), bad);
        end
        n_vec++;
        if (cursor_x !== 5'd0 || cursor_y !== 5'd0) begin
            n_err++;
            $display("FAIL lf_cursor: cx=%0d cy=%0d, required 0,0", cursor_x, cursor_y);
        end
    endtask

    task automatic test_backspace();
        do_reset();
        put(8'h61); put(8'h62); put(8'h08);
        n_vec++;
        if (reg_char_we !== 4'hF || reg_char_di !== 32'h0001_0020 || cursor_x !== 5'd1) begin
            n_err++;
            $display("FAIL bs_first: we=%h di=%h cx=%0d, required we=f di=00010020 cx=1",
                     reg_char_we, reg_char_di, cursor_x);
        end
        put(8'h08);
        n_vec++;
        if (reg_char_we !== 4'hF || reg_char_di !== 32'h0000_0020 || cursor_x !== 5'd0) begin
            n_err++;
            $display("FAIL bs_second: we=%h di=%h cx=%0d, required we=f di=00000020 cx=0",
                     reg_char_we, reg_char_di, cursor_x);
        end
        put(8'h08);
        n_vec++;
        if (reg_char_we !== 4'h0 || cursor_x !== 5'd0 || cursor_y !== 5'd0) begin
            n_err++;
            $display("FAIL bs_at_col0: we=%h cx=%0d cy=%0d, required we=0 cx=0 cy=0",
                     reg_char_we, cursor_x, cursor_y);
        end
    endtask

    task automatic test_formfeed();
        int idx, bad, busy_bad, cyc;
        do_reset();
        put(8'h41); put(8'h0A); put(8'h42);
        settle();
        put(8'h0C);
        idx = 0; bad = -1; busy_bad = 0; cyc = 0;
        while (in_ready !== 1'b1 && cyc < 2000) begin
            if (reg_char_we === 4'hF) begin
                if (bad < 0 && reg_char_di !== word(idx % int'(COLS), idx / int'(COLS), 32)) bad = idx;
                idx++;
            end
            if (busy !== 1'b1) busy_bad++;
            @(negedge clk);
            cyc++;
        end
        n_vec++;
        if (idx != 896 || bad >= 0) begin
            n_err++;
            $display("FAIL ff_writes: %0d writes, first out-of-order %0d, required 896 row-major", idx, bad);
        end
        n_vec++;
        if (busy_bad != 0 || busy !== 1'b0 || cursor_x !== 5'd0 || cursor_y !== 5'd0) begin
            n_err++;
            $display("FAIL ff_busy: busy-low cycles %0d, end busy=%b cx=%0d cy=%0d, required 0,0,0,0",
                     busy_bad, busy, cursor_x, cursor_y);
        end
    endtask

    task automatic test_reset_mid_clear();
        int seen, cyc, stray;
        do_reset();
        put(8'h0C);
        seen = 1; cyc = 0;
        while (seen < 100 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (reg_char_we === 4'hF) seen++;
        end
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({reg_char_we, reg_char_di, cursor_x, cursor_y, in_ready, busy} !== 48'h0) begin
            n_err++;
            $display("FAIL midclear_reset: we=%h di=%h cx=%0d cy=%0d rdy=%b busy=%b, required all zero",
                     reg_char_we, reg_char_di, cursor_x, cursor_y, in_ready, busy);
        end
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            if (reg_char_we !== 4'h0) stray++;
        end
        reset = 1'b0;
        @(negedge clk);
        if (reg_char_we !== 4'h0) stray++;
        n_vec++;
        if (stray != 0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midclear_after: %0d stray writes, rdy=%b, required 0 writes rdy=1", stray, in_ready);
        end
        settle();
    endtask

    task automatic test_misc_bytes();
        do_reset();
        put(8'h78);
        put(8'h07);
        n_vec++;
        if (reg_char_we !== 4'h0 || cursor_x !== 5'd1 || cursor_y !== 5'd0) begin
            n_err++;
            $display("FAIL drop_bel: we=%h cx=%0d cy=%0d, required we=0 cx=1 cy=0",
                     reg_char_we, cursor_x, cursor_y);
        end
        put(8'hC1);
        n_vec++;
        if (reg_char_we !== 4'hF || reg_char_di !== 32'h0001_003F || cursor_x !== 5'd2) begin
            n_err++;
            $display("FAIL high_byte: we=%h di=%h cx=%0d, required we=f di=0001003f cx=2",
                     reg_char_we, reg_char_di, cursor_x);
        end
        put(8'h1B); put(8'd40); put(8'd40);
        n_vec++;
        if (reg_char_we !== 4'h0 || cursor_x !== 5'd31 || cursor_y !== 5'd27) begin
            n_err++;
            $display("FAIL esc_clamp: we=%h cx=%0d cy=%0d, required we=0 cx=31 cy=27",
                     reg_char_we, cursor_x, cursor_y);
        end
    endtask

    task automatic test_back_to_back();
        longint t0, t1;
        do_reset();
        put(8'h48);
        t0 = $time;
        put(8'h69);
        put(8'h21);
        t1 = $time;
        n_vec++;
        if (t1 - t0 != 20 || reg_char_di !== 32'h0002_0021 || cursor_x !== 5'd3) begin
            n_err++;
            $display("FAIL back_to_back: span=%0d ns di=%h cx=%0d, required 20 ns di=00020021 cx=3",
                     t1 - t0, reg_char_di, cursor_x);
        end
    endtask

    function automatic logic [7:0] rand_byte();
        int sel;
        sel = int'($urandom_range(0, 99));
        if (sel < 55)      return 8'($urandom_range(32, 126));
        else if (sel < 62) return 8'h0A;
        else if (sel < 66) return 8'h0D;
        else if (sel < 74) return 8'h08;
        else if (sel < 80) return 8'h1B;
        else if (sel < 88) return 8'($urandom_range(128, 255));
        else if (sel < 96) return 8'($urandom_range(0, 31));
        else               return 8'h7F;
    endfunction

    task automatic test_random();
        logic [7:0] b;
        int bad;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            b = rand_byte();
            put(b);
            n_vec++;
            if (cursor_x !== 5'(mx) || cursor_y !== 5'(my)) begin
                n_err++;
                $display("FAIL rand_cursor[%0d]: byte=%h cx=%0d cy=%0d, required cx=%0d cy=%0d",
                         i, b, cursor_x, cursor_y, mx, my);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        settle();
        bad = -1;
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
            if (bad < 0 && cap_q[i] !== {4'hF, exp_q[i]}) bad = i;
        n_vec++;
        if (cap_q.size() != exp_q.size() || bad >= 0) begin
            n_err++;
            $display("FAIL rand_writes: got %0d writes, required %0d, first bad index %0d",
                     cap_q.size(), exp_q.size(), bad);
        end
    endtask

    initial begin
        mx = 0; my = 0; mesc = 0;
        test_reset();
        test_printable();
        test_wrap();
        test_lf_last_row();
        test_backspace();
        test_formfeed();
        test_reset_mid_clear();
        test_misc_bytes();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/text_console.md
# text_console

Byte-stream terminal writer that drives the character-write register port of the on-screen text display. It accepts ASCII bytes over a valid/ready handshake and tracks a cursor. It interprets a small set of control codes and emits one `{x, y, char}` word write per cycle into the 32x28 character buffer. It sits between the PicoRV32 I/O bus (or any byte source, e.g. a debug UART) and the text display, and performs all line wrapping and screen/line clearing in hardware.

## Interface
Parameters:
- `COLS`, 32, columns per row (1..32)
- `ROWS`, 28, rows per screen (1..32)

Ports:
- `clk` in 1: main logic clock. This is the only clock.
- `reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: input byte valid.
- `in_data` in 8: input byte.
- `in_ready` out 1: block accepts the byte when `in_valid && in_ready`.
- `reg_char_we` out 4: display write strobe. Value is 4'hF for one cycle per write, else 4'h0.
- `reg_char_di` out 32: display write word, laid out as `{8'h00, 3'b0, x[4:0], 3'b0, y[4:0], char[7:0]}`.
- `cursor_x` out 5: current column.
- `cursor_y` out 5: current row.
- `busy` out 1: high while a clear sequence runs. Equals `~in_ready` outside reset.

## Operation
- All outputs are registered.
- Reset values:
  - `reg_char_we` = 0, `reg_char_di` = 0.
  - `cursor_x` = 0, `cursor_y` = 0.
  - `in_ready` = 0 and `busy` = 0 while `reset` is high.
  - The escape state is cleared.
- FSM states: IDLE, ESC_X, ESC_Y, CLRLINE, CLRALL.
  - `in_ready` = 1 in IDLE, ESC_X and ESC_Y.
  - `in_ready` = 0 in CLRLINE and CLRALL.
- Byte handling in IDLE:
  - **0x20–0x7E (printable):** write the byte at (cx, cy). Then set cx = cx+1. If cx was COLS-1, set cx = 0, cy = (cy+1) mod ROWS, and enter CLRLINE for the new cy.
  - **0x80–0xFF:** handled as printable, but the written char is 0x3F ('?').
  - **0x0A (LF):** cx = 0, cy = (cy+1) mod ROWS, enter CLRLINE. No character write.
  - **0x0D (CR):** cx = 0. No write.
  - **0x08 (BS):** if cx > 0, set cx = cx-1 and write 0x20 at the new cx. At cx = 0, no-op.
  - **0x0C (FF):** cursor = (0,0), enter CLRALL.
  - **0x1B (ESC):** go to ESC_X.
  - **All other bytes 0x00–0x1F and 0x7F:** dropped silently. Cursor is unchanged.
- Escape sequence:
  - ESC_X: the next byte sets the column, cx = min(byte, COLS-1). Go to ESC_Y.
  - ESC_Y: the next byte sets the row, cy = min(byte, ROWS-1). Return to IDLE.
  - Neither step writes to the display or clears anything.
- CLRLINE:
  - Writes 0x20 at x = 0..COLS-1 on row cy, one write per cycle, in ascending x.
  - Returns to IDLE after the write at x = COLS-1.
- CLRALL:
  - Writes 0x20 for y = 0..ROWS-1 (outer loop) and x = 0..COLS-1 (inner loop), one write per cycle.
  - Returns to IDLE after writing (COLS-1, ROWS-1).
- Wrap-around: the row after ROWS-1 is row 0. There is no scroll; the new row is cleared instead.
- Arithmetic:
  - The x and y counters are 5-bit.
  - Wrap compares are against COLS-1 and ROWS-1, not against 5-bit overflow.
- Handshake: while `in_ready` = 0, `in_valid` and `in_data` are ignored and nothing is consumed.
- Reset asserted mid-clear or mid-escape:
  - The sequence aborts at the next edge.
  - All outputs return to their reset values.
  - No further writes are issued.

## Timing
- A byte accepted at edge T produces its `reg_char_we` pulse and the updated cursor at edge T+1. Throughput is one printable byte per cycle.
- Cursor outputs always show the post-command position. During CLRLINE/CLRALL they already hold the final cursor.
- CLRLINE:
  - `in_ready` falls at T+1.
  - The clear writes occupy T+1..T+COLS. The first is x = 0 at T+1 when the triggering byte caused no character write.
  - When a wrap-causing printable byte triggers the clear, that byte's write occurs at T+1 and the clear writes occupy T+2..T+COLS+1.
  - `in_ready` returns one cycle after the last clear write.
- CLRALL: the same pattern, lasting COLS*ROWS cycles (896 with default parameters).
- After `reset` deasserts, `in_ready` rises one cycle later.

## Configuration
- `TEXT_CONSOLE_CLEAR_EN` defined:
  - On the first cycle after reset deasserts, the block enters CLRALL automatically.
  - It issues COLS*ROWS writes of 0x20 with `in_ready` = 0.
  - It then enters IDLE with the cursor at (0,0).
- Not defined: the block goes straight to IDLE after reset and does not touch the display.

## Test plan
- **Printable byte:** reset, then send 'A' (0x41). Expect one write with `reg_char_di` = 32'h0000_0041 at T+1, followed by `cursor_x` = 1.
- **Wrap at end of row:** ESC, 31, 5, then 'Z'. Expect a write of 32'h001F_055A, then 32 writes of char 0x20 on y = 6 (x = 0..31). `in_ready` stays low for those 32 cycles, and the cursor ends at (0,6).
- **LF on the last row:** ESC, 0, 27, then 0x0A. Expect 32 clear writes on y = 0 and the cursor at (0,0).
- **Backspace:** send 'a', 'b', 0x08. Expect a final write of 32'h0001_0020 and `cursor_x` = 1. Then send 0x08 twice more: one write at x = 0, then a no-op with no write.
- **Form feed and mid-clear reset:** send 0x0C. Expect 896 writes in row-major order with `busy` = 1. Repeat, and assert `reset` at clear write 100: writes stop the next cycle and all outputs are zero.
- **Dropped, high and ESC-clamped bytes:** send 0x07. Expect no write and the cursor unchanged. Send 0xC1. Expect char 0x3F to be written. Send ESC, 40, 40. Expect the cursor at (31,27).
